// File: rtl/teclado_pkg.sv
// Shared definitions for the keypad digit accumulator: one-hot row/column
// codes of the 4x4 keypad and the key codes produced by the decoder.
package teclado_pkg;

    // One-hot row codes: row1 holds 1,2,3 and row4 holds *,0,#
    localparam logic [3:0] ROW1 = 4'b1000;
    localparam logic [3:0] ROW2 = 4'b0100;
    localparam logic [3:0] ROW3 = 4'b0010;
    localparam logic [3:0] ROW4 = 4'b0001;

    // One-hot column codes: col4 carries the letter keys A-D
    localparam logic [3:0] COL1 = 4'b1000;
    localparam logic [3:0] COL2 = 4'b0100;
    localparam logic [3:0] COL3 = 4'b0010;
    localparam logic [3:0] COL4 = 4'b0001;

    // Key codes 0-9 are the digit values themselves
    typedef logic [3:0] key_t;

    localparam key_t KEY_ENTER = 4'hE;
    localparam key_t KEY_CLEAR = 4'hC;
    localparam key_t KEY_NONE  = 4'hF;

    // True when the key code is a decimal digit
    function automatic logic is_digit(input key_t k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/teclado_decod.sv
// Combinational keypad decoder: maps a one-hot row/column pair to a key
// code. Letter keys and any non-one-hot or empty pattern decode to KEY_NONE.
module teclado_decod
    import teclado_pkg::*;
(
    input  logic [3:0] lin,
    input  logic [3:0] col,
    output logic [3:0] key
);

    // Look up the key at the intersection of the active row and column
    always_comb begin
        key = KEY_NONE;
        case ({lin, col})
            {ROW1, COL1}: key = 4'd1;
            {ROW1, COL2}: key = 4'd2;
            {ROW1, COL3}: key = 4'd3;
            {ROW2, COL1}: key = 4'd4;
            {ROW2, COL2}: key = 4'd5;
            {ROW2, COL3}: key = 4'd6;
            {ROW3, COL1}: key = 4'd7;
            {ROW3, COL2}: key = 4'd8;
            {ROW3, COL3}: key = 4'd9;
            {ROW4, COL1}: key = KEY_CLEAR;
            {ROW4, COL2}: key = 4'd0;
            {ROW4, COL3}: key = KEY_ENTER;
            default:      key = KEY_NONE;
        endcase
    end

endmodule

// File: rtl/teclado_conta.sv
// Keypad digit accumulator: synchronizes the key-press strobe, detects its
// rising edge, decodes the pressed key and shifts decimal digits into a
// DIGITS-wide BCD accumulator. Enter publishes the accumulator on s with a
// one-cycle s_valid pulse; '*' clears the partial entry.
// Optional feature macro: TECLADO_DEBOUNCE_EN adds a filter requiring the
// synchronized strobe to stay high DEBOUNCE_CYCLES clocks before acceptance.
module teclado_conta
    import teclado_pkg::*;
#(
    parameter int DIGITS          = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            lin,
    input  logic [3:0]            col,
    input  logic                  bot_press,
    output logic [4*DIGITS-1:0]   s,
    output logic                  s_valid
);

    localparam int W = 4 * DIGITS;

    // The shift expression needs at least two nibbles and the filter at
    // least one sample; anything smaller is a configuration error
    if (DIGITS < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("teclado_conta: DIGITS must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic         sync1_q, sync1_d;
    logic         sync2_q, sync2_d;
    logic         stable;
    logic         prev_q, prev_d;
    logic         press_edge;
    logic [3:0]   key;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] s_q, s_d;
    logic         s_valid_q, s_valid_d;

    // Two-flop synchronizer inputs for the asynchronous press strobe
    always_comb begin
        sync1_d = bot_press;
        sync2_d = sync1_q;
    end

    // Synchronizer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef TECLADO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic          deb_q, deb_d;

    // Count consecutive high samples; the filtered level rises on the sample
    // that completes DEBOUNCE_CYCLES highs and drops on any low sample
    always_comb begin
        deb_cnt_d = '0;
        deb_d     = 1'b0;
        if (sync2_q) begin
            deb_cnt_d = deb_cnt_q;
            if (deb_cnt_q != CW'(DEBOUNCE_CYCLES)) begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
            deb_d = (deb_cnt_q >= CW'(DEBOUNCE_CYCLES - 1));
        end
    end

    // Debounce counter and filtered level registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_q <= '0;
            deb_q     <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            deb_q     <= deb_d;
        end
    end

    assign stable = deb_q;
`else
    assign stable = sync2_q;
`endif

    // Rising-edge detect: a held key yields a single action
    always_comb begin
        prev_d     = stable;
        press_edge = stable & ~prev_q;
    end

    // Previous-level register for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    teclado_decod u_decod (
        .lin (lin),
        .col (col),
        .key (key)
    );

    // Act on the decoded key only in the edge cycle; digits shift in at the
    // bottom and push the oldest digit out of the top nibble
    always_comb begin
        acc_d     = acc_q;
        s_d       = s_q;
        s_valid_d = 1'b0;
        if (press_edge) begin
            if (is_digit(key)) begin
                acc_d = {acc_q[W-5:0], key};
            end else if (key == KEY_ENTER) begin
                s_d       = acc_q;
                acc_d     = '0;
                s_valid_d = 1'b1;
            end else if (key == KEY_CLEAR) begin
                acc_d = '0;
            end
        end
    end

    // Accumulator and published-value registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            s_q       <= '0;
            s_valid_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            s_q       <= s_d;
            s_valid_q <= s_valid_d;
        end
    end

    assign s       = s_q;
    assign s_valid = s_valid_q;

endmodule

// File: tb/tb_teclado_conta.sv
// Testbench for teclado_conta: directed key sequences followed by random
// presses. A decimal model of the entry predicts each published value and
// the cycle it appears; a separate monitor pops and compares on s_valid.
module tb_teclado_conta;

    localparam int DIGITS = 3;
    localparam int DEB    = 4;
`ifdef TECLADO_DEBOUNCE_EN
    localparam int LAT  = 3 + DEB;
    localparam int HOLD = DEB + 1;
`else
    localparam int LAT  = 3;
    localparam int HOLD = 2;
`endif
    localparam int MOD = 10 ** DIGITS;

    typedef struct {
        logic [4*DIGITS-1:0] value;
        int                  cycle;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic [3:0]          lin;
    logic [3:0]          col;
    logic                bot_press;
    logic [4*DIGITS-1:0] s;
    logic                s_valid;

    exp_t                sbQ[$];
    int                  checks;
    int                  errors;
    int                  cycleCount;
    int                  acc;
    logic [4*DIGITS-1:0] lastS;
    string               keyMap = "123A456B789C*0#D";

    teclado_conta #(
        .DIGITS          (DIGITS),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lin       (lin),
        .col       (col),
        .bot_press (bot_press),
        .s         (s),
        .s_valid   (s_valid)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so the monitor can check latency
    initial begin
        cycleCount = 0;
        forever begin
            @(posedge clk);
            cycleCount = cycleCount + 1;
        end
    end

    // Decimal value to packed BCD, least significant digit in the low nibble
    function automatic logic [4*DIGITS-1:0] toBcd(input int v);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        end
        return r;
    endfunction

    // Compare one observed value with its expectation and tally the result
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d",
                     name, actual, expected, cycleCount);
        end
    endtask

    // Press one key position for 'hold' clocks; the model decides from the
    // keypad layout what the press means and queues any published value
    task automatic applyStimulus(input logic [3:0] l, input logic [3:0] c,
                                 input int hold);
        byte  ch;
        int   r;
        int   cc;
        logic accepted;
        @(negedge clk);
        lin       = l;
        col       = c;
        bot_press = 1'b1;
        ch        = " ";
        r         = 0;
        cc        = 0;
        if ($onehot(l) && $onehot(c)) begin
            for (int i = 0; i < 4; i++) begin
                if (l == (4'b1000 >> i)) r = i;
                if (c == (4'b1000 >> i)) cc = i;
            end
            ch = keyMap[r*4 + cc];
        end
`ifdef TECLADO_DEBOUNCE_EN
        accepted = (hold >= DEB);
`else
        accepted = (hold >= 1);
`endif
        if (accepted) begin
            if (ch >= "0" && ch <= "9") begin
                acc = (acc * 10 + (int'(ch) - 48)) % MOD;
            end else if (ch == "#") begin
                sbQ.push_back('{toBcd(acc), cycleCount + LAT});
                acc = 0;
            end else if (ch == "*") begin
                acc = 0;
            end
        end
        repeat (hold) @(negedge clk);
        bot_press = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        lin = 4'($urandom);
        col = 4'($urandom);
        repeat (2) @(negedge clk);
    endtask

    // Press a key identified by its legend character
    task automatic pressChar(input byte ch, input int hold);
        int         idx;
        logic [3:0] l;
        logic [3:0] c;
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            if (keyMap[i] == ch) idx = i;
        end
        l = 4'b1000 >> (idx / 4);
        c = 4'b1000 >> (idx % 4);
        applyStimulus(l, c, hold);
    endtask

    // Press each character of a string with the default hold time
    task automatic pressString(input string str);
        for (int i = 0; i < str.len(); i++) begin
            pressChar(str[i], HOLD);
        end
    endtask

    // Monitor: every published value must match the head of the scoreboard
    // and arrive on the predicted cycle; otherwise s must hold its last value
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (s_valid === 1'b1) begin
                    if (sbQ.size() == 0) begin
                        checks = checks + 1;
                        errors = errors + 1;
                        $display("[TB] FAIL unexpected_valid: got s=%0h with no pending Enter at cycle %0d",
                                 s, cycleCount);
                    end else begin
                        e = sbQ.pop_front();
                        checkOutput("s_value", 32'(s), 32'(e.value));
                        checkOutput("s_latency", 32'(cycleCount), 32'(e.cycle));
                        lastS = e.value;
                    end
                end else begin
                    checkOutput("s_hold", 32'(s), 32'(lastS));
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        repeat (60000) @(posedge clk);
        errors = errors + 1;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus: directed sequences, then random presses
    initial begin
        checks    = 0;
        errors    = 0;
        acc       = 0;
        lastS     = '0;
        rst_n     = 1'b0;
        bot_press = 1'b0;
        lin       = 4'h0;
        col       = 4'h0;
        #1;
        checkOutput("reset_s", 32'(s), 32'h0);
        checkOutput("reset_s_valid", 32'(s_valid), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        pressString("267#");
        pressString("8#");
        pressString("493#");
        pressString("05#");
        pressString("1234#");
        pressString("5*6#");

        pressChar("1", HOLD);
        applyStimulus(4'h8, 4'h1, HOLD);
        applyStimulus(4'h3, 4'h4, HOLD);
        pressChar("2", HOLD);
        pressChar("#", HOLD);

        pressChar("7", 20);
        pressChar("#", HOLD);

`ifdef TECLADO_DEBOUNCE_EN
        pressChar("9", DEB - 1);
        pressChar("#", HOLD);
`endif

        pressString("93");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_s", 32'(s), 32'h0);
        checkOutput("midreset_s_valid", 32'(s_valid), 32'h0);
        acc   = 0;
        lastS = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pressString("#");

        for (int n = 0; n < 150; n++) begin
            int sel;
            int hold;
            int idx;
            logic [3:0] l;
            logic [3:0] c;
`ifdef TECLADO_DEBOUNCE_EN
            hold = $urandom_range(1, DEB + 2);
`else
            hold = $urandom_range(1, 4);
`endif
            sel = $urandom_range(0, 99);
            if (sel < 25) begin
                pressChar("#", hold);
            end else if (sel < 80) begin
                idx = $urandom_range(0, 15);
                l   = 4'b1000 >> (idx / 4);
                c   = 4'b1000 >> (idx % 4);
                applyStimulus(l, c, hold);
            end else begin
                applyStimulus(4'($urandom), 4'($urandom), hold);
            end
        end

        repeat (LAT + 5) @(negedge clk);
        checkOutput("queue_drained", 32'(sbQ.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/teclado_conta.md
Name: teclado_conta

Overview:
- Accepts key presses from a 4x4 matrix keypad and accumulates decimal digits into a 3-digit BCD number.
- The number is published on `s` when the Enter key ('#') is pressed.
- Sits between the keypad scanner/press detector and the alarm-time logic of the digital alarm.
- Single clock domain; `bot_press` and the `lin`/`col` inputs are asynchronous to `clk`.

Parameters:
- DIGITS, 3, number of BCD digits held; output width is 4*DIGITS.
- DEBOUNCE_CYCLES, 4, number of consecutive stable clk samples of `bot_press` required (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lin  in  4  keypad row, one-hot: 8=row1 (1,2,3), 4=row2 (4,5,6), 2=row3 (7,8,9), 1=row4 (*,0,#).
- col  in  4  keypad column, one-hot: 8=col1 (1,4,7,*), 4=col2 (2,5,8,0), 2=col3 (3,6,9,#), 1=col4 (A,B,C,D).
- bot_press  in  1  key-pressed strobe, active high, asynchronous.
- s  out  4*DIGITS  last entered value in BCD; most significant digit in the top nibble.
- s_valid  out  1  one-clk pulse when `s` is updated.

Behaviour:
- Reset (async, rst_n=0): accumulator=0, s=0, s_valid=0, synchronizer flops=0.
- `bot_press` passes through a 2-flop synchronizer, then rising-edge detection (sync2 & ~prev).
- `lin`/`col` are sampled in the edge cycle. They must be stable from `bot_press` rise until 3 clk later.
- Key decode (combinational, unique one-hot pair):
  - Digits 0-9 per the row/column map above.
  - '#' (lin=1, col=2) = Enter.
  - '*' (lin=8'… i.e. lin=1, col=8) = Clear.
  - col=1 keys (A-D) = no-op.
  - Any non-one-hot or zero `lin`/`col` = no-op.
- Digit press: acc <= {acc[4*DIGITS-5:0], digit}, i.e. shift left one nibble.
  - A 4th digit drops the oldest one (wrap-around discards the MSD).
- Enter: s <= acc, acc <= 0, s_valid=1 for one cycle.
  - Enter with an empty accumulator publishes 0.
- Clear: acc <= 0; `s` unchanged; no s_valid.
- No-op keys: no state change.
- Latency: `s` updates on the 3rd rising clk edge after `bot_press` rises (2 sync + 1 register).
- `bot_press` held high produces exactly one action; the next action requires a low period of at least 2 clk.
- Digits are never added: `s` is always valid BCD (each nibble 0-9).
- Reset asserted mid-entry discards partial digits and clears `s`.

Optional Feature:
- Macro: TECLADO_DEBOUNCE_EN.
- When defined: after the synchronizer, `bot_press` must be stable high for DEBOUNCE_CYCLES consecutive clk before the edge is accepted. Latency becomes 2+DEBOUNCE_CYCLES+1 clk. Pulses shorter than DEBOUNCE_CYCLES are ignored.
- When undefined: no debounce filter; latency is 3 clk as above.

Decomposition:
- Shared package `teclado_pkg` holds:
  - one-hot row/column constants (ROW1..ROW4, COL1..COL4);
  - key code typedef (4-bit);
  - constants KEY_ENTER=4'hE, KEY_CLEAR=4'hC, KEY_NONE=4'hF.
- One sub-module, `teclado_decod`: purely combinational `lin`/`col` -> key code.
- Synchronizer, edge detect, optional debounce and accumulator stay in `teclado_conta`.

Test Plan:
- Keys 2 (8,4), 6 (4,2), 7 (2,8), Enter (1,2) -> s=0x267, s_valid pulses once.
- Key 8 (2,4), Enter -> s=0x008.
- Keys 4 (4,8), 9 (2,2), 3 (8,2), Enter -> s=0x493. Then keys 0 (1,4), 5 (4,4), Enter -> s=0x005.
- Keys 1,2,3,4, Enter -> s=0x234 (overflow drops MSD). Keys 5, '*', 6, Enter -> s=0x006.
- Key A (lin=8, col=1) and invalid lin=3, col=4 between digits 1 and 2, then Enter -> s=0x012; `bot_press` held high 20 clk -> single digit entered.
- Assert rst_n low after two digits -> s=0, s_valid=0 immediately. After release, Enter -> s=0x000.
